// File: rtl/booth_digit_decoder.sv
// Radix-4 Booth digit-stream decoder: accumulates the signed 64-bit product and rebuilds the multiplier.
// Optional macro BOOTH_NZ_COUNT_EN adds nz_count, the number of accepted non-zero digits per operation.
module booth_digit_decoder #(
    parameter int N    = 32,
    parameter int NDIG = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   md,
    input  logic           digit_valid,
    input  logic           digit_neg,
    input  logic           digit_one,
    input  logic           digit_two,
    output logic           digit_ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [N-1:0]   mr_rec,
    output logic           err
`ifdef BOOTH_NZ_COUNT_EN
    ,
    output logic [4:0]     nz_count
`endif
);

    localparam int IW = $clog2(NDIG);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   md_q, md_d;
    logic [N-1:0]   mr_q, mr_d;
    logic [2*N-1:0] prod_q, prod_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           err_q, err_d;

    logic           accept;
    logic           illegal;
    logic [2*N-1:0] md_ext;
    logic [2*N-1:0] mag_term;
    logic [2*N-1:0] prod_term;
    logic [N-1:0]   mr_mag;
    logic [N-1:0]   mr_term;
    logic [IW:0]    shamt;

    always_comb begin
        accept   = (state_q == ACCUM) && digit_valid;
        illegal  = digit_one && digit_two;
        md_ext   = {{N{md_q[N-1]}}, md_q};
        mag_term = '0;
        mr_mag   = '0;
        // one&two together is illegal and contributes zero; neg with zero magnitude is just zero
        if (digit_two && !digit_one) begin
            mag_term = md_ext << 1;
            mr_mag   = N'(2);
        end else if (digit_one && !digit_two) begin
            mag_term = md_ext;
            mr_mag   = N'(1);
        end
        shamt     = {idx_q, 1'b0};
        prod_term = (digit_neg ? -mag_term : mag_term) << shamt;
        mr_term   = (digit_neg ? -mr_mag : mr_mag) << shamt;

        state_d = state_q;
        md_d    = md_q;
        mr_d    = mr_q;
        prod_d  = prod_q;
        idx_d   = idx_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    md_d    = md;
                    mr_d    = '0;
                    prod_d  = '0;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    prod_d = prod_q + prod_term;
                    mr_d   = mr_q + mr_term;
                    err_d  = err_q || illegal;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == IW'(NDIG - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            md_q    <= '0;
            mr_q    <= '0;
            prod_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            md_q    <= md_d;
            mr_q    <= mr_d;
            prod_q  <= prod_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign digit_ready = (state_q == ACCUM);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign product     = prod_q;
    assign mr_rec      = mr_q;
    assign err         = err_q;

`ifdef BOOTH_NZ_COUNT_EN
    logic [4:0] nz_q, nz_d;

    // Exactly one of one/two set means a non-zero digit; the illegal pattern counts as zero
    always_comb begin
        nz_d = nz_q;
        if (state_q == IDLE && start) begin
            nz_d = '0;
        end else if (accept && (digit_one ^ digit_two)) begin
            nz_d = nz_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nz_q <= '0;
        end else begin
            nz_q <= nz_d;
        end
    end

    assign nz_count = nz_q;
`endif

endmodule

// File: tb/tb_booth_digit_decoder.sv
// Self-checking bench for booth_digit_decoder: directed vector table, mid-operation reset, and random
// operations against an arithmetic reference model.
module tb_booth_digit_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] md;
    logic        digit_valid;
    logic        digit_neg;
    logic        digit_one;
    logic        digit_two;
    logic        digit_ready;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] mr_rec;
    logic        err;
`ifdef BOOTH_NZ_COUNT_EN
    logic [4:0]  nz_count;
`endif

    always #5 clk = ~clk;

    booth_digit_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .md          (md),
        .digit_valid (digit_valid),
        .digit_neg   (digit_neg),
        .digit_one   (digit_one),
        .digit_two   (digit_two),
        .digit_ready (digit_ready),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .mr_rec      (mr_rec),
        .err         (err)
`ifdef BOOTH_NZ_COUNT_EN
        ,
        .nz_count    (nz_count)
`endif
    );

    typedef struct {
        string            name;
        logic [31:0]      md;
        logic [15:0][2:0] digs;
        int               gap;
        logic [63:0]      exp_p;
        logic [31:0]      exp_m;
        logic             exp_e;
        logic [4:0]       exp_nz;
    } vec_t;

    vec_t vecs[5];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Digit codes are {neg, one, two}; the multiplier is the weighted digit sum, product is md times it
    function automatic void ref_model(input logic [31:0] md_v, input logic [15:0][2:0] digs,
                                      output logic [63:0] p, output logic [31:0] m,
                                      output logic e, output logic [4:0] nz);
        longint   mr_full = 0;
        longint   w       = 1;
        longint   prod;
        longint   d;
        logic [2:0] c;
        e  = 1'b0;
        nz = '0;
        for (int i = 0; i < 16; i++) begin
            c = digs[i];
            if (c[1] && c[0]) begin
                e = 1'b1;
                d = 0;
            end else begin
                d = c[0] ? 2 : (c[1] ? 1 : 0);
                if (c[2]) d = -d;
            end
            if (d != 0) nz++;
            mr_full += d * w;
            w = w * 4;
        end
        prod = longint'($signed(md_v)) * mr_full;
        p = prod;
        m = mr_full[31:0];
    endfunction

    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, ".digit_ready"}, 64'(digit_ready), 64'd0);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
        checkOutput({tag, ".done"}, 64'(done), 64'd0);
        checkOutput({tag, ".product"}, product, 64'd0);
        checkOutput({tag, ".mr_rec"}, 64'(mr_rec), 64'd0);
        checkOutput({tag, ".err"}, 64'(err), 64'd0);
`ifdef BOOTH_NZ_COUNT_EN
        checkOutput({tag, ".nz_count"}, 64'(nz_count), 64'd0);
`endif
    endtask

    // Runs one operation; n_feed < 16 leaves it mid-flight for an abort test
    task automatic applyStimulus(input string name, input logic [31:0] md_v, input logic [15:0][2:0] digs,
                                 input int gap, input int n_feed, input bit hold_start,
                                 input logic [63:0] exp_p, input logic [31:0] exp_m,
                                 input logic exp_e, input logic [4:0] exp_nz);
        bit ready_ok = 1'b1;
        start = 1'b1;
        md    = md_v;
        @(posedge clk); #1;
        start = hold_start;
        md    = $urandom;
        checkOutput({name, ".busy_after_start"}, 64'(busy), 64'd1);
        checkOutput({name, ".err_after_start"}, 64'(err), 64'd0);
        for (int i = 0; i < n_feed; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    digit_valid = 1'b0;
                    {digit_neg, digit_one, digit_two} = 3'($urandom);
                    if (digit_ready !== 1'b1) ready_ok = 1'b0;
                    @(posedge clk); #1;
                end
            end
            if (digit_ready !== 1'b1) ready_ok = 1'b0;
            digit_valid = 1'b1;
            {digit_neg, digit_one, digit_two} = digs[i];
            @(posedge clk); #1;
        end
        digit_valid = 1'b0;
        start       = 1'b0;
        {digit_neg, digit_one, digit_two} = 3'b000;
        if (gap > 0) checkOutput({name, ".ready_in_gaps"}, 64'(ready_ok), 64'd1);
        if (n_feed == 16) begin
            checkOutput({name, ".done"}, 64'(done), 64'd1);
            checkOutput({name, ".busy_done"}, 64'(busy), 64'd1);
            checkOutput({name, ".ready_done"}, 64'(digit_ready), 64'd0);
            checkOutput({name, ".product"}, product, exp_p);
            checkOutput({name, ".mr_rec"}, 64'(mr_rec), 64'(exp_m));
            checkOutput({name, ".err"}, 64'(err), 64'(exp_e));
`ifdef BOOTH_NZ_COUNT_EN
            checkOutput({name, ".nz_count"}, 64'(nz_count), 64'(exp_nz));
`endif
            @(posedge clk); #1;
            checkOutput({name, ".done_one_cycle"}, 64'(done), 64'd0);
            checkOutput({name, ".busy_idle"}, 64'(busy), 64'd0);
            checkOutput({name, ".product_hold"}, product, exp_p);
            checkOutput({name, ".err_hold"}, 64'(err), 64'(exp_e));
        end
    endtask

    logic [15:0][2:0] rdigs;
    logic [63:0]      rp;
    logic [31:0]      rm;
    logic             re;
    logic [4:0]       rnz;
    logic [2:0]       legal_codes [6];

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        md          = '0;
        digit_valid = 1'b0;
        {digit_neg, digit_one, digit_two} = 3'b000;

        vecs[0].name = "plus5";
        vecs[0].md = 32'd3; vecs[0].digs = '0; vecs[0].digs[0] = 3'b010; vecs[0].digs[1] = 3'b010;
        vecs[0].gap = 0; vecs[0].exp_p = 64'hF; vecs[0].exp_m = 32'h5; vecs[0].exp_e = 1'b0; vecs[0].exp_nz = 5'd2;

        vecs[1].name = "neg1_negzero";
        vecs[1].md = 32'hFFFFFFF9;
        for (int i = 0; i < 16; i++) vecs[1].digs[i] = 3'b100;
        vecs[1].digs[0] = 3'b110;
        vecs[1].gap = 0; vecs[1].exp_p = 64'h7; vecs[1].exp_m = 32'hFFFFFFFF; vecs[1].exp_e = 1'b0; vecs[1].exp_nz = 5'd1;

        vecs[2].name = "minus2_top";
        vecs[2].md = 32'h7FFFFFFF; vecs[2].digs = '0; vecs[2].digs[15] = 3'b101;
        vecs[2].gap = 0; vecs[2].exp_p = 64'hC000000080000000; vecs[2].exp_m = 32'h80000000;
        vecs[2].exp_e = 1'b0; vecs[2].exp_nz = 5'd1;

        vecs[3] = vecs[0];
        vecs[3].name = "plus5_gaps";
        vecs[3].gap  = 3;

        vecs[4] = vecs[0];
        vecs[4].name = "illegal_idx4";
        vecs[4].digs[4] = 3'b011;
        vecs[4].exp_e   = 1'b1;

        legal_codes[0] = 3'b000; legal_codes[1] = 3'b001; legal_codes[2] = 3'b010;
        legal_codes[3] = 3'b100; legal_codes[4] = 3'b101; legal_codes[5] = 3'b110;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkIdleZero("reset");

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].name, vecs[v].md, vecs[v].digs, vecs[v].gap, 16, 1'b0,
                          vecs[v].exp_p, vecs[v].exp_m, vecs[v].exp_e, vecs[v].exp_nz);
        end

        applyStimulus("abort", 32'h12345678, vecs[1].digs, 0, 7, 1'b0, '0, '0, 1'b0, '0);
        pulseReset();
        checkIdleZero("mid_reset");
        applyStimulus("after_reset", vecs[0].md, vecs[0].digs, 0, 16, 1'b0,
                      vecs[0].exp_p, vecs[0].exp_m, vecs[0].exp_e, vecs[0].exp_nz);

        applyStimulus("start_overlap", vecs[2].md, vecs[2].digs, 1, 16, 1'b1,
                      vecs[2].exp_p, vecs[2].exp_m, vecs[2].exp_e, vecs[2].exp_nz);

        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 24) == 0) rdigs[i] = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b011;
                else rdigs[i] = legal_codes[$urandom_range(0, 5)];
            end
            md = $urandom;
            ref_model(md, rdigs, rp, rm, re, rnz);
            applyStimulus($sformatf("rand%0d", k), md, rdigs, int'($urandom_range(0, 2)), 16,
                          1'($urandom_range(0, 1)), rp, rm, re, rnz);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
